mem_request_scheduler: RTL

// - Upstream feeder of the DRAM memory model. Buffers core memory requests and issues at most one per cycle.
// - Issue uses the m_grant/instruction handshake.
// - Policy is row-hit-first with an oldest-first fallback and a starvation guard.
// - Per-channel credits mirror the memory's 10-entry BASR slots, so an issued request is never dropped.

---
 rtl/mem_request_scheduler_pkg.sv | 36 +++
 rtl/mem_request_scheduler_if.sv | 26 ++
 rtl/mem_request_scheduler_req_select_tree.sv | 49 ++++
 rtl/mem_request_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_request_scheduler_pkg.sv
// Shared definitions for the memory request scheduler.
// - Address field positions inside a 32-bit request word ([31] = write flag).
// - Default credit ceiling per channel (BASR slots per channel in the memory).
// - Queue entry record and small field-extraction helpers.
package mem_request_scheduler_pkg;

  localparam int unsigned CHAN_BIT          = 25;
  localparam int unsigned BANK_MSB          = 25;
  localparam int unsigned BANK_LSB          = 18;
  localparam int unsigned ROW_MSB           = 17;
  localparam int unsigned ROW_LSB           = 10;
  localparam int unsigned WRITE_BIT         = 31;
  localparam int unsigned SLOTS_PER_CHANNEL = 10;

  // Wait counters saturate at STARVE_LIMIT; 8 bits covers limits up to 255.
  localparam int unsigned WAIT_W = 8;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [WAIT_W-1:0] wait_cnt;
  } q_entry_t;

  function automatic logic chan_of(input logic [31:0] instr);
    return instr[CHAN_BIT];
  endfunction

  function automatic logic [7:0] bank_of(input logic [31:0] instr);
    return instr[BANK_MSB:BANK_LSB];
  endfunction

  function automatic logic [7:0] row_of(input logic [31:0] instr);
    return instr[ROW_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/mem_request_scheduler_if.sv
// Request/issue/completion bundle between cores, scheduler and memory model.
// - req_valid/req_instruction/req_ready : core request handshake
// - m_grant/instruction/write_enable    : one-cycle issue to memory
// - mem_request/data                    : memory completion (data[25] = channel)
// slave  : the scheduler side
// master : the environment (cores + memory) side
interface mem_request_scheduler_if;
  logic        req_valid;
  logic [31:0] req_instruction;
  logic        req_ready;
  logic        m_grant;
  logic [31:0] instruction;
  logic        write_enable;
  logic        mem_request;
  logic [31:0] data;

  modport slave (
    input  req_valid, req_instruction, mem_request, data,
    output req_ready, m_grant, instruction, write_enable
  );

  modport master (
    output req_valid, req_instruction, mem_request, data,
    input  req_ready, m_grant, instruction, write_enable
  );
endinterface

// File: rtl/mem_request_scheduler_req_select_tree.sv
// Combinational priority pick over the request queue.
// - eligible : per-entry valid and channel credit available
// - hit      : per-entry predicted row hit
// - wait_cnt : per-entry saturating wait counter
// - found    : some entry is eligible
// - index    : chosen entry
// Order: starving entries (wait >= STARVE_LIMIT) first, then row hits, then
// anything; within a class the largest wait wins, ties go to the lowest index.
module req_select_tree
  import mem_request_scheduler_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned STARVE_LIMIT = 16,
  localparam int unsigned IDX_W       = $clog2(QUEUE_DEPTH)
) (
  input  logic [QUEUE_DEPTH-1:0] eligible,
  input  logic [QUEUE_DEPTH-1:0] hit,
  input  logic [WAIT_W-1:0]      wait_cnt [QUEUE_DEPTH],
  output logic                   found,
  output logic [IDX_W-1:0]       index
);

  // Key = {starving, hit-but-not-starving, wait}: starving entries rank by
  // wait alone, everything else ranks hit-before-miss then by wait.
  logic [WAIT_W+1:0] best_key;
  logic [WAIT_W+1:0] key;
  logic              starving;

  always_comb begin
    found    = 1'b0;
    index    = '0;
    best_key = '0;
    key      = '0;
    starving = 1'b0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if (eligible[i]) begin
        starving = (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT));
        key      = {starving, hit[i] & ~starving, wait_cnt[i]};
        // strict compare keeps the lowest index on ties
        if (!found || key > best_key) begin
          found    = 1'b1;
          index    = IDX_W'(i);
          best_key = key;
        end
      end
    end
  end

endmodule

// File: rtl/mem_request_scheduler.sv
// Memory request scheduler: buffers core requests and issues at most one per
// cycle to the DRAM model, row-hit-first with oldest-first fallback and a
// starvation guard. Per-channel credits mirror the memory's BASR slots.
// Ports:
// - clock, reset     : rising-edge clock, synchronous active-high reset
// - bus (slave)      : request, issue and completion handshakes
// - queue_count      : occupied queue entries
// - hit_issue_count  : issues predicted as row hits (wraps)
// - issue_count      : total issues (wraps)
// - credit_error     : sticky, completion seen while channel credit at ceiling
module mem_request_scheduler #(
  parameter int unsigned QUEUE_DEPTH       = 8,
  parameter int unsigned SLOTS_PER_CHANNEL = mem_request_scheduler_pkg::SLOTS_PER_CHANNEL,
  parameter int unsigned NUM_BANKS         = 256,
  parameter int unsigned STARVE_LIMIT      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  mem_request_scheduler_if.slave        bus,
  output logic [3:0]                    queue_count,
  output logic [31:0]                   hit_issue_count,
  output logic [31:0]                   issue_count,
  output logic                          credit_error
);
  import mem_request_scheduler_pkg::*;

  localparam int unsigned IDX_W    = $clog2(QUEUE_DEPTH);
  localparam int unsigned CREDIT_W = $clog2(SLOTS_PER_CHANNEL + 1);

  q_entry_t              queue_q   [QUEUE_DEPTH];
  logic [CREDIT_W-1:0]   credits   [2];
  logic [CREDIT_W-1:0]   credit_nxt [2];
  logic                  credit_overflow;
  logic [NUM_BANKS-1:0]  row_valid;
  logic [7:0]            open_row  [NUM_BANKS];

  logic [QUEUE_DEPTH-1:0] eligible;
  logic [QUEUE_DEPTH-1:0] hit;
  logic [WAIT_W-1:0]      wait_cnt [QUEUE_DEPTH];
  logic [IDX_W-1:0]       free_idx;
  logic                   full;
  logic [3:0]             count;
  logic                   enq;

  logic                   found;
  logic [IDX_W-1:0]       sel_idx;
  logic [31:0]            sel_instr;
  logic                   sel_hit;

  // Only the channel bit of the completion word matters here.
  logic unused_data;
  assign unused_data = ^{bus.data[31:CHAN_BIT+1], bus.data[CHAN_BIT-1:0]};

  always_comb begin
    free_idx = '0;
    full     = 1'b1;
    count    = '0;
    eligible = '0;
    hit      = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      wait_cnt[i] = queue_q[i].wait_cnt;
      if (queue_q[i].valid) begin
        count       = count + 4'd1;
        eligible[i] = (credits[chan_of(queue_q[i].instr)] != '0);
        hit[i]      = row_valid[bank_of(queue_q[i].instr)] &&
                      (open_row[bank_of(queue_q[i].instr)] == row_of(queue_q[i].instr));
      end else if (full) begin
        free_idx = IDX_W'(i);
        full     = 1'b0;
      end
    end
  end

  assign bus.req_ready = ~full;
  assign queue_count   = count;
  assign enq           = bus.req_valid & ~full;

  req_select_tree #(
    .QUEUE_DEPTH  (QUEUE_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .eligible (eligible),
    .hit      (hit),
    .wait_cnt (wait_cnt),
    .found    (found),
    .index    (sel_idx)
  );

  assign sel_instr = queue_q[sel_idx].instr;
  assign sel_hit   = hit[sel_idx];

  // Return and issue on the same channel cancel; a lone return at the ceiling
  // is dropped and flagged.
  always_comb begin
    credit_nxt      = credits;
    credit_overflow = 1'b0;
    for (int unsigned c = 0; c < 2; c++) begin
      if (bus.mem_request && (bus.data[CHAN_BIT] == 1'(c)) &&
          !(found && (chan_of(sel_instr) == 1'(c)))) begin
        if (credits[c] == CREDIT_W'(SLOTS_PER_CHANNEL)) credit_overflow = 1'b1;
        else credit_nxt[c] = credits[c] + 1'b1;
      end else if (!(bus.mem_request && (bus.data[CHAN_BIT] == 1'(c))) &&
                   found && (chan_of(sel_instr) == 1'(c))) begin
        credit_nxt[c] = credits[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= '0;
      for (int unsigned c = 0; c < 2; c++) credits[c] <= CREDIT_W'(SLOTS_PER_CHANNEL);
      row_valid        <= '0;
      bus.m_grant      <= 1'b0;
      bus.instruction  <= '0;
      bus.write_enable <= 1'b0;
      issue_count      <= '0;
      hit_issue_count  <= '0;
      credit_error     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        if (queue_q[i].valid && queue_q[i].wait_cnt < WAIT_W'(STARVE_LIMIT))
          queue_q[i].wait_cnt <= queue_q[i].wait_cnt + 1'b1;
      end
      credits          <= credit_nxt;
      if (credit_overflow) credit_error <= 1'b1;
      bus.m_grant      <= found;
      bus.write_enable <= found & sel_instr[WRITE_BIT];
      if (found) begin
        queue_q[sel_idx].valid       <= 1'b0;
        bus.instruction              <= sel_instr;
        row_valid[bank_of(sel_instr)] <= 1'b1;
        issue_count                  <= issue_count + 32'd1;
        if (sel_hit) hit_issue_count <= hit_issue_count + 32'd1;
      end
      // free_idx is always a currently-empty slot, never the one issuing now
      if (enq) queue_q[free_idx] <= '{valid: 1'b1, instr: bus.req_instruction, wait_cnt: '0};
    end
  end

  // Row contents need no reset: row_valid guards every read.
  always_ff @(posedge clock) begin
    if (found) open_row[bank_of(sel_instr)] <= row_of(sel_instr);
  end

endmodule
